// File: rtl/game_undo_history.sv
// Multi-level undo/redo history: circular buffer of DEPTH board states with registered current state.
// Optional REDO support enabled by defining GAME_UNDO_REDO_EN.
module game_undo_history #(
    parameter int unsigned STATE_W = 134,
    parameter int unsigned DEPTH   = 8,
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_state_en,
    input  logic [1:0]         sel,
    input  logic [STATE_W-1:0] game_state_int,
    input  logic [STATE_W-1:0] game_state_mm,
    output logic [STATE_W-1:0] game_state,
    output logic               real_retract,
    output logic               real_redo,
    output logic [PTR_W-1:0]   undo_cnt,
    output logic [PTR_W-1:0]   redo_cnt,
    output logic               hist_full
);

    localparam logic [1:0] CMD_LOAD = 2'd0;
    localparam logic [1:0] CMD_MOVE = 2'd1;
    localparam logic [1:0] CMD_UNDO = 2'd2;
    localparam logic [1:0] CMD_REDO = 2'd3;
    localparam logic [PTR_W-1:0] CNT_MAX = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);

    logic [STATE_W-1:0] hist [DEPTH];
    logic [PTR_W-1:0]   ptr;

    logic [PTR_W-1:0]   ptr_nxt;
    logic [STATE_W-1:0] state_nxt;
    logic [PTR_W-1:0]   undo_nxt;
    logic [PTR_W-1:0]   redo_nxt;
    logic               retract_nxt;
    logic               redo_pulse_nxt;
    logic               wr_en;
    logic [PTR_W-1:0]   wr_idx;
    logic [STATE_W-1:0] wr_data;

    // Command decode: next pointer, counters, current state and buffer write.
    always_comb begin
        ptr_nxt        = ptr;
        state_nxt      = game_state;
        undo_nxt       = undo_cnt;
        redo_nxt       = redo_cnt;
        retract_nxt    = 1'b0;
        redo_pulse_nxt = 1'b0;
        wr_en          = 1'b0;
        wr_idx         = ptr;
        wr_data        = game_state_int;
        if (game_state_en) begin
            case (sel)
                CMD_LOAD: begin
                    wr_en     = 1'b1;
                    wr_idx    = '0;
                    wr_data   = game_state_int;
                    ptr_nxt   = '0;
                    undo_nxt  = '0;
                    redo_nxt  = '0;
                    state_nxt = game_state_int;
                end
                CMD_MOVE: begin
                    // At full history the oldest slot is simply overwritten.
                    wr_en     = 1'b1;
                    wr_idx    = ptr + ONE;
                    wr_data   = game_state_mm;
                    ptr_nxt   = ptr + ONE;
                    state_nxt = game_state_mm;
                    redo_nxt  = '0;
                    if (undo_cnt != CNT_MAX) begin
                        undo_nxt = undo_cnt + ONE;
                    end
                end
                CMD_UNDO: begin
                    if (undo_cnt != '0) begin
                        ptr_nxt     = ptr - ONE;
                        state_nxt   = hist[ptr - ONE];
                        undo_nxt    = undo_cnt - ONE;
`ifdef GAME_UNDO_REDO_EN
                        redo_nxt    = redo_cnt + ONE;
`endif
                        retract_nxt = 1'b1;
                    end
                end
                CMD_REDO: begin
`ifdef GAME_UNDO_REDO_EN
                    if (redo_cnt != '0) begin
                        ptr_nxt        = ptr + ONE;
                        state_nxt      = hist[ptr + ONE];
                        redo_nxt       = redo_cnt - ONE;
                        undo_nxt       = undo_cnt + ONE;
                        redo_pulse_nxt = 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // History storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            hist[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            game_state   <= '0;
            undo_cnt     <= '0;
            redo_cnt     <= '0;
            real_retract <= 1'b0;
            real_redo    <= 1'b0;
            hist_full    <= 1'b0;
        end else begin
            ptr          <= ptr_nxt;
            game_state   <= state_nxt;
            undo_cnt     <= undo_nxt;
            redo_cnt     <= redo_nxt;
            real_retract <= retract_nxt;
            real_redo    <= redo_pulse_nxt;
            hist_full    <= (undo_nxt == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_game_undo_history.sv
// Scoreboard bench for game_undo_history; the reference model is a stack of states plus a redo stack.
module tb_game_undo_history;

    localparam int unsigned STATE_W = 134;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned PTR_W   = $clog2(DEPTH);

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic               retract;
        logic               redo_p;
        logic [PTR_W-1:0]   undo;
        logic [PTR_W-1:0]   redo;
        logic               full;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               game_state_en = 1'b0;
    logic [1:0]         sel = 2'd0;
    logic [STATE_W-1:0] game_state_int = '0;
    logic [STATE_W-1:0] game_state_mm = '0;
    logic [STATE_W-1:0] game_state;
    logic               real_retract;
    logic               real_redo;
    logic [PTR_W-1:0]   undo_cnt;
    logic [PTR_W-1:0]   redo_cnt;
    logic               hist_full;

    game_undo_history #(.STATE_W(STATE_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .game_state_en  (game_state_en),
        .sel            (sel),
        .game_state_int (game_state_int),
        .game_state_mm  (game_state_mm),
        .game_state     (game_state),
        .real_retract   (real_retract),
        .real_redo      (real_redo),
        .undo_cnt       (undo_cnt),
        .redo_cnt       (redo_cnt),
        .hist_full      (hist_full)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [STATE_W-1:0] mh [$];
    logic [STATE_W-1:0] mr [$];
    exp_t               sb [$];

    task automatic check(input string tag, input logic [STATE_W-1:0] act, input logic [STATE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [STATE_W-1:0] rnd_state();
        logic [159:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return w[STATE_W-1:0];
    endfunction

    task automatic model_reset();
        mh.delete();
        mr.delete();
        mh.push_back('0);
        sb.delete();
    endtask

    // Apply one command to the model and queue the expected post-edge outputs.
    task automatic model_cmd(input bit en, input logic [1:0] s, input logic [STATE_W-1:0] d);
        exp_t e;
        e = '0;
        if (en) begin
            case (s)
                2'd0: begin mh.delete(); mr.delete(); mh.push_back(d); end
                2'd1: begin
                    mh.push_back(d);
                    if (mh.size() > DEPTH) void'(mh.pop_front());
                    mr.delete();
                end
                2'd2: if (mh.size() > 1) begin
`ifdef GAME_UNDO_REDO_EN
                    mr.push_back(mh[$]);
`endif
                    void'(mh.pop_back());
                    e.retract = 1'b1;
                end
                default: begin
`ifdef GAME_UNDO_REDO_EN
                    if (mr.size() > 0) begin
                        mh.push_back(mr.pop_back());
                        e.redo_p = 1'b1;
                    end
`endif
                end
            endcase
        end
        e.state = mh[$];
        e.undo  = PTR_W'(mh.size() - 1);
        e.redo  = PTR_W'(mr.size());
        e.full  = (mh.size() == DEPTH);
        sb.push_back(e);
    endtask

    task automatic cmd(input bit en, input logic [1:0] s, input logic [STATE_W-1:0] d);
        exp_t e;
        @(negedge clk);
        game_state_en  = en;
        sel            = s;
        game_state_int = d;
        game_state_mm  = d;
        model_cmd(en, s, d);
        @(posedge clk);
        #1;
        game_state_en = 1'b0;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("state",   game_state, e.state);
            check("retract", STATE_W'(real_retract), STATE_W'(e.retract));
            check("redo_p",  STATE_W'(real_redo), STATE_W'(e.redo_p));
            check("undo",    STATE_W'(undo_cnt), STATE_W'(e.undo));
            check("redo",    STATE_W'(redo_cnt), STATE_W'(e.redo));
            check("full",    STATE_W'(hist_full), STATE_W'(e.full));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, game_state, '0);
        check({tag, "_undo"},  STATE_W'(undo_cnt), '0);
        check({tag, "_redo"},  STATE_W'(redo_cnt), '0);
        check({tag, "_flags"}, STATE_W'({real_retract, real_redo, hist_full}), '0);
    endtask

    initial begin
        logic [STATE_W-1:0] a;
        logic [1:0]         s;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Load, two moves, undo past the start.
        a = rnd_state();
        cmd(1, 2'd0, a);
        cmd(1, 2'd1, rnd_state());
        cmd(1, 2'd1, rnd_state());
        cmd(1, 2'd2, '0);
        cmd(1, 2'd2, '0);
        cmd(1, 2'd2, '0);
        cmd(0, 2'd1, rnd_state());

        // Fill and wrap the history, then drain it.
        cmd(1, 2'd0, rnd_state());
        for (int i = 0; i < 9; i++) cmd(1, 2'd1, rnd_state());
        for (int i = 0; i < 8; i++) cmd(1, 2'd2, '0);

        // Redo behaviour (no-ops when redo is not built in).
        cmd(1, 2'd0, rnd_state());
        cmd(1, 2'd1, rnd_state());
        cmd(1, 2'd2, '0);
        cmd(1, 2'd3, '0);
        cmd(1, 2'd2, '0);
        cmd(1, 2'd1, rnd_state());
        cmd(1, 2'd3, '0);

        // Random traffic after a load.
        cmd(1, 2'd0, rnd_state());
        for (int i = 0; i < 150; i++) begin
            s = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) s = 2'd0;
            cmd($urandom_range(0, 7) != 0, s, rnd_state());
        end

        // Async reset between MOVE and UNDO.
        cmd(1, 2'd1, rnd_state());
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cmd(1, 2'd2, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
